// File: rtl/apb_cmd_master.sv
// APB4 master fed by a valid/ready command stream through a small FIFO, one response per command.
// Optional ACCESS-phase timeout: define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int STRB_W     = DATA_W / 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              apb_clk_i,
  input  logic              apb_resetn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0] cmd_strb_i,
  input  logic [2:0]        cmd_prot_i,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] apb_addr_o,
  output logic              apb_sel_o,
  output logic              apb_enable_o,
  output logic              apb_write_o,
  output logic [STRB_W-1:0] apb_strb_o,
  output logic [2:0]        apb_prot_o,
  output logic [DATA_W-1:0] apb_wdata_o,
  input  logic              apb_ready_i,
  input  logic [DATA_W-1:0] apb_rdata_i,
  input  logic              apb_slverr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if ((DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_cmd_master: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic [2:0]        prot;
    logic [STRB_W-1:0] strb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t           state, state_next;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full, empty, push, pop;
  logic             start, done, timeout_hit;

  // ---------------- command FIFO ----------------
  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign cmd_ready_o  = apb_resetn_i && !full;
  assign push         = cmd_valid_i && cmd_ready_o;
  assign pop          = done;
  assign head         = mem[rd_ptr];
  assign fifo_level_o = level;

  always_ff @(posedge apb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{write: cmd_write_i, prot: cmd_prot_i, strb: cmd_strb_i,
                       addr: cmd_addr_i, wdata: cmd_wdata_i};
    end
  end

  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- transfer FSM ----------------
  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!rsp_valid_o || rsp_ready_i)) begin
          state_next = SETUP;
          start      = 1'b1;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (apb_ready_i || timeout_hit) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign apb_sel_o    = (state != IDLE);
  assign apb_enable_o = (state == ACCESS);

  // Address/control are latched on SETUP entry and deliberately left untouched in IDLE.
  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) begin
      apb_addr_o  <= '0;
      apb_write_o <= 1'b0;
      apb_strb_o  <= '0;
      apb_prot_o  <= '0;
      apb_wdata_o <= '0;
    end else if (start) begin
      apb_addr_o  <= head.addr;
      apb_write_o <= head.write;
      apb_strb_o  <= head.write ? head.strb : '0;
      apb_prot_o  <= head.prot;
      apb_wdata_o <= head.wdata;
    end
  end

  // ---------------- optional ACCESS timeout ----------------
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] wait_cnt;

  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i)                          wait_cnt <= '0;
    else if (state == SETUP)                    wait_cnt <= '0;
    else if (state == ACCESS && !apb_ready_i)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYC-th stalled ACCESS cycle; a PREADY in that cycle still completes normally.
  assign timeout_hit = (state == ACCESS) && !apb_ready_i && (wait_cnt == TC_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------- response buffer ----------------
  always_ff @(posedge apb_clk_i) begin
    if (!apb_resetn_i) begin
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else if (done) begin
      rsp_valid_o   <= 1'b1;
      rsp_rdata_o   <= (apb_write_o || timeout_hit) ? '0 : apb_rdata_i;
      rsp_err_o     <= timeout_hit ? 1'b1 : apb_slverr_i;
      rsp_timeout_o <= timeout_hit;
    end else if (rsp_ready_i) begin
      rsp_valid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed commands, behavioural APB slave, queued expected responses.
module tb_apb_cmd_master;

  localparam int ADDR_W = 32, DATA_W = 32, FIFO_DEPTH = 4, TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic [2:0]  level;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] apb_addr, apb_wdata, apb_rdata;
  logic        apb_sel, apb_enable, apb_write, apb_ready, apb_slverr;
  logic [3:0]  apb_strb;
  logic [2:0]  apb_prot;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                   .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .apb_clk_i(clk), .apb_resetn_i(resetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .cmd_prot_i(cmd_prot), .fifo_level_o(level),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .apb_addr_o(apb_addr), .apb_sel_o(apb_sel), .apb_enable_o(apb_enable),
    .apb_write_o(apb_write), .apb_strb_o(apb_strb), .apb_prot_o(apb_prot),
    .apb_wdata_o(apb_wdata), .apb_ready_i(apb_ready), .apb_rdata_i(apb_rdata),
    .apb_slverr_i(apb_slverr)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0, failures = 0;

  int          sl_wait = 0;
  int          cur_setup = 0, cur_acc = 0, last_setup = 0, last_acc = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_strb = '0;
  logic [2:0]  last_prot = '0;
  logic        last_write = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [31:0] r, input logic e, input logic t);
    mk = {r, e, t};
  endfunction

  // Slave: PREADY held low for sl_wait ACCESS cycles; read data = ~addr except 0x20; PSLVERR at 0x44.
  always @(negedge clk) begin
    if (apb_sel && !apb_enable) begin
      cur_setup = cur_setup + 1;
      cur_acc   = 0;
    end else if (apb_sel && apb_enable) begin
      cur_acc = cur_acc + 1;
    end else begin
      cur_setup = 0;
    end
    apb_ready  = apb_sel && apb_enable && (cur_acc > sl_wait);
    apb_rdata  = (apb_addr == 32'h20) ? 32'h12345678 : ~apb_addr;
    apb_slverr = (apb_addr == 32'h44);
    if (apb_sel && apb_enable) begin
      last_setup = cur_setup;
      last_acc   = cur_acc;
      last_addr  = apb_addr;
      last_wdata = apb_wdata;
      last_strb  = apb_strb;
      last_prot  = apb_prot;
      last_write = apb_write;
    end
  end

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (resetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {rsp_rdata, rsp_err, rsp_timeout}, e);
      end
    end
  end

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input rsp_t e);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", 64'd1, 64'd0);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sel_seen;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_sel_en", {apb_sel, apb_enable}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_apb_regs", {apb_addr, apb_strb, apb_write}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Single write, zero wait states
    sl_wait = 0;
    push(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b010, mk(32'h0, 1'b0, 1'b0));
    wait_drain();
    chk("t1_setup_cycles", last_setup, 1);
    chk("t1_access_cycles", last_acc, 1);
    chk("t1_addr", last_addr, 32'h10);
    chk("t1_wdata", last_wdata, 32'hCAFEF00D);
    chk("t1_strb_write", {last_strb, last_write}, {4'hF, 1'b1});
    chk("t1_prot", last_prot, 3'b010);
    chk("t1_idle_hold", {apb_sel, apb_addr}, {1'b0, 32'h10});

    // Read with three wait states
    sl_wait = 3;
    push(1'b0, 32'h20, 32'hDEADBEEF, 4'hF, 3'b000, mk(32'h12345678, 1'b0, 1'b0));
    wait_drain();
    chk("t2_access_cycles", last_acc, 4);
    chk("t2_read_strb", {last_strb, last_write}, {4'h0, 1'b0});
    chk("t2_addr", last_addr, 32'h20);

    // FIFO fill with response back-pressure
    sl_wait = 0;
    @(posedge clk); #1 rsp_ready = 1'b0;
    push(1'b1, 32'h30, 32'h11111111, 4'h3, 3'b001, mk(32'h0, 1'b0, 1'b0));
    push(1'b0, 32'h34, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFFCB, 1'b0, 1'b0));
    push(1'b0, 32'h38, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFFC7, 1'b0, 1'b0));
    push(1'b1, 32'h3C, 32'h22222222, 4'hC, 3'b000, mk(32'h0, 1'b0, 1'b0));
    push(1'b0, 32'h40, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFFBF, 1'b0, 1'b0));
    @(negedge clk);
    chk("t3_level_full", level, 4);
    chk("t3_cmd_ready_full", cmd_ready, 0);
    chk("t3_rsp_held", {rsp_valid, rsp_rdata}, {1'b1, 32'h0});
    repeat (3) @(negedge clk);
    chk("t3_no_new_xfer", apb_sel, 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_drain();
    chk("t3_level_empty", level, 0);

    // Slave error followed by a normal read
    push(1'b0, 32'h44, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFFBB, 1'b1, 1'b0));
    push(1'b0, 32'h48, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFFB7, 1'b0, 1'b0));
    wait_drain();

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    sl_wait = 1000;
    push(1'b0, 32'h80, 32'h0, 4'hF, 3'b000, mk(32'h0, 1'b1, 1'b1));
    wait_drain();
    chk("t5_timeout_access_cycles", last_acc, 16);
    sl_wait = 15;
    push(1'b0, 32'h84, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFF7B, 1'b0, 1'b0));
    wait_drain();
    chk("t5_ready_at_limit_cycles", last_acc, 16);
`else
    sl_wait = 20;
    push(1'b0, 32'h84, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFF7B, 1'b0, 1'b0));
    wait_drain();
    chk("t5_long_wait_cycles", last_acc, 21);
`endif

    // Reset during ACCESS with two commands queued behind the active one
    sl_wait = 1000;
    push(1'b0, 32'h100, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFEFF, 1'b0, 1'b0));
    push(1'b0, 32'h104, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFEFB, 1'b0, 1'b0));
    push(1'b0, 32'h108, 32'h0, 4'hF, 3'b000, mk(32'hFFFFFEF7, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (!(apb_sel && apb_enable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_access", {apb_sel, apb_enable}, 2'b11);
    chk("t6_level_before", level, 3);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("t6_sel_en_dropped", {apb_sel, apb_enable}, 0);
    chk("t6_level_cleared", level, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready_in_rst", cmd_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sl_wait = 0;
    sel_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (apb_sel || rsp_valid) sel_seen++;
    end
    chk("t6_no_activity_after_rst", sel_seen, 0);
    push(1'b1, 32'h200, 32'h5A5A5A5A, 4'hF, 3'b000, mk(32'h0, 1'b0, 1'b0));
    wait_drain();
    chk("t6_recovery_addr", last_addr, 32'h200);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
